regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter.sv | 86 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Two writeback sources (A: execute, B: load/multi-cycle) share one RF write port.
// Ready is combinational from the valids and the last-grant state. The accepted
// write is registered and shows up on the RF port for exactly one cycle.
// Writes to x0 are accepted but never reach the RF.
// Build option: RF_ARB_RR_EN selects round-robin on contention. When it is not
// defined, A has fixed priority. The last-grant state is tracked either way.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a_valid,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic                  o_a_ready,
  input  logic                  i_b_valid,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  output logic                  o_b_ready,
  output logic                  o_reg_write,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_last_grant
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_LAST_A = 2'b01;
  localparam logic [1:0] ST_LAST_B = 2'b10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [1:0] state_q, state_d;
  logic       b_wins;
  logic       xfer;
  wr_req_t    sel;
  wr_req_t    wr_q, wr_d;
  logic       reg_write_q, reg_write_d;

`ifdef RF_ARB_RR_EN
  // On contention, B wins only when A took the previous grant.
  assign b_wins = (state_q == ST_LAST_A);
`else
  // On contention, A always wins.
  assign b_wins = 1'b0;
`endif

  // Readies depend only on the valids and the state. Reset forces them low.
  assign o_a_ready = ~i_rst & i_a_valid & ~(i_b_valid & b_wins);
  assign o_b_ready = ~i_rst & i_b_valid & (~i_a_valid | b_wins);
  assign xfer      = o_a_ready | o_b_ready;

  // Select the granted write. Track the last grant. Drop x0 writes from the RF port.
  always_comb begin
    state_d     = state_q;
    sel         = '{addr: i_a_addr, data: i_a_data};
    if (o_b_ready) sel = '{addr: i_b_addr, data: i_b_data};
    if (o_a_ready) state_d = ST_LAST_A;
    else if (o_b_ready) state_d = ST_LAST_B;
    reg_write_d = xfer & (|sel.addr);
    wr_d        = reg_write_d ? sel : wr_q;
  end

  // State and RF-port registers. Address and data hold when no write is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      reg_write_q <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      wr_q        <= wr_d;
    end
  end

  assign o_reg_write  = reg_write_q;
  assign o_rd_addr    = wr_q.addr;
  assign o_rd_data    = wr_q.data;
  assign o_last_grant = state_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter. Expected values are hand-computed.
// Define RF_ARB_RR_EN for both the bench and the RTL to check round-robin behaviour.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  last_grant;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_reg_write(reg_write), .o_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_last_grant(last_grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests after the falling edge, then check the readies.
  // Return #1 after the next rising edge so the caller can check the registered outputs.
  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                     input logic exp_ar, input logic exp_br, input string tag);
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    chk({tag, ".a_rdy"}, 32'(a_ready), 32'(exp_ar));
    chk({tag, ".b_rdy"}, 32'(b_ready), 32'(exp_br));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic eb;
    logic [4:0] last_addr;
    logic [31:0] last_data;

    // Reset holds the readies low even with both valids high.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h2;
    @(posedge clk); #1;
    chk("rst.a_rdy", 32'(a_ready), 0);
    chk("rst.b_rdy", 32'(b_ready), 0);
    chk("rst.wr", 32'(reg_write), 0);
    chk("rst.grant", 32'(last_grant), 0);
    chk("rst.addr", 32'(rd_addr), 0);
    chk("rst.data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;

    // Single write from A.
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, "single");
    chk("single.wr", 32'(reg_write), 1);
    chk("single.addr", 32'(rd_addr), 5);
    chk("single.data", rd_data, 32'hDEADBEEF);
    chk("single.grant", 32'(last_grant), 1);
    cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, "single_idle");
    chk("single_idle.wr", 32'(reg_write), 0);
    chk("single_idle.addr", 32'(rd_addr), 5);
    chk("single_idle.data", rd_data, 32'hDEADBEEF);

    // Four cycles of contention, starting from IDLE.
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_RR_EN
      eb = (i % 2 == 1);
`else
      eb = 1'b0;
`endif
      cyc(1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i, !eb, eb, $sformatf("cont%0d", i));
      chk($sformatf("cont%0d.wr", i), 32'(reg_write), 1);
      chk($sformatf("cont%0d.addr", i), 32'(rd_addr), eb ? 2 : 1);
      chk($sformatf("cont%0d.data", i), rd_data, eb ? 32'hB0 + i : 32'hA0 + i);
      chk($sformatf("cont%0d.grant", i), 32'(last_grant), eb ? 2 : 1);
    end
`ifdef RF_ARB_RR_EN
    last_addr = 5'd2; last_data = 32'hB3;
`else
    last_addr = 5'd1; last_data = 32'hA3;
`endif

    // A write to x0 is accepted but dropped.
    cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, "x0");
    chk("x0.wr", 32'(reg_write), 0);
    chk("x0.addr", 32'(rd_addr), 32'(last_addr));
    chk("x0.data", rd_data, last_data);
    chk("x0.grant", 32'(last_grant), 2);

    // Both sources write x7: A wins first, then B is written on the next cycle.
    do_reset();
    cyc(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 1, 0, "same0");
    chk("same0.wr", 32'(reg_write), 1);
    chk("same0.data", rd_data, 32'h11);
    cyc(0, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 1, "same1");
    chk("same1.wr", 32'(reg_write), 1);
    chk("same1.addr", 32'(rd_addr), 7);
    chk("same1.data", rd_data, 32'h22);

    // Reset arrives just after A's transfer edge and wipes the write without a clock edge.
    cyc(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 0, "mid");
    chk("mid.wr_pre", 32'(reg_write), 1);
    rst = 1'b1;
    #1;
    chk("mid.wr_async", 32'(reg_write), 0);
    chk("mid.grant_async", 32'(last_grant), 0);
    chk("mid.a_rdy_async", 32'(a_ready), 0);
    @(posedge clk); #1;
    chk("mid.wr_next", 32'(reg_write), 0);
    chk("mid.addr", 32'(rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;

    // The first edge after reset arbitrates from IDLE, so A wins.
    cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 0, "post");
    chk("post.addr", 32'(rd_addr), 3);
    chk("post.grant", 32'(last_grant), 1);

    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety timeout: the bench always terminates on its own.
  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule
